// File: rtl/uart_program_loader_if.sv
// Byte stream from the UART receiver plus the instruction-memory write port.
// The loader sits on the master side. The UART and memory environment sits on the slave side.
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  io_data_valid;
    logic [7:0]            io_data_packet;
    logic                  io_mem_write_enable;
    logic [ADDR_WIDTH-1:0] io_mem_address;
    logic [31:0]           io_mem_write_data;

    modport master (
        input  io_data_valid,
        input  io_data_packet,
        output io_mem_write_enable,
        output io_mem_address,
        output io_mem_write_data
    );

    modport slave (
        output io_data_valid,
        output io_data_packet,
        input  io_mem_write_enable,
        input  io_mem_address,
        input  io_mem_write_data
    );
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader. It parses a UART image with this layout:
//   - a 4-byte little-endian word count,
//   - the payload words,
//   - an 8-bit additive checksum.
// It writes each payload word into instruction memory.
// The core stays in reset until the checksum matches.
module uart_program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_program_loader_if.master bus,
    input  logic                  io_reload,
    output logic                  io_cpu_reset_n,
    output logic                  io_load_done,
    output logic                  io_load_error
);
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;
    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int          IW        = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_LENGTH,
        S_WORD,
        S_CHECKSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_reg, state_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [31:0]           word_reg, word_next;
    logic [31:0]           count_reg, count_next;
    logic [IW-1:0]         index_reg, index_next;
    logic [7:0]            checksum_reg, checksum_next;
    logic [TW-1:0]         timeout_reg, timeout_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [31:0]           data_reg, data_next;
    logic                  cpu_rst_n_reg, cpu_rst_n_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;

    logic [31:0]   assembled;
    logic [IW-1:0] index_inc;
    logic          timer_run;

    // Next-state logic.
    // Reload wins over a byte arriving in the same cycle.
    // Every in-frame byte restarts the inter-byte timer.
    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        word_next      = word_reg;
        count_next     = count_reg;
        index_next     = index_reg;
        checksum_next  = checksum_reg;
        timeout_next   = timeout_reg;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        data_next      = data_reg;
        cpu_rst_n_next = cpu_rst_n_reg;
        done_next      = done_reg;
        error_next     = error_reg;

        assembled = word_reg;
        assembled[{byte_cnt_reg, 3'b000} +: 8] = bus.io_data_packet;
        index_inc = index_reg + IW'(1);

        // Timer runs once a frame has started, until done or error.
        timer_run = (state_reg == S_LENGTH && byte_cnt_reg != 2'd0)
                 || state_reg == S_WORD || state_reg == S_CHECKSUM;

        if (io_reload) begin
            state_next     = S_LENGTH;
            byte_cnt_next  = '0;
            word_next      = '0;
            count_next     = '0;
            index_next     = '0;
            checksum_next  = '0;
            timeout_next   = '0;
            cpu_rst_n_next = 1'b0;
            done_next      = 1'b0;
            error_next     = 1'b0;
        end else if (bus.io_data_valid &&
                     (state_reg == S_LENGTH || state_reg == S_WORD ||
                      state_reg == S_CHECKSUM)) begin
            timeout_next = '0;
            case (state_reg)
                S_LENGTH: begin
                    checksum_next = checksum_reg + bus.io_data_packet;
                    word_next     = assembled;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        count_next = assembled;
                        if (assembled == 32'd0) begin
                            state_next = S_CHECKSUM;
                        end else if (assembled > MAX_WORDS) begin
                            state_next = S_ERROR;
                            error_next = 1'b1;
                        end else begin
                            state_next = S_WORD;
                        end
                    end
                end
                S_WORD: begin
                    checksum_next = checksum_reg + bus.io_data_packet;
                    word_next     = assembled;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        we_next    = 1'b1;
                        addr_next  = index_reg[ADDR_WIDTH-1:0];
                        data_next  = assembled;
                        index_next = index_inc;
                        if (32'(index_inc) == count_reg) begin
                            state_next = S_CHECKSUM;
                        end
                    end
                end
                default: begin
                    if (bus.io_data_packet == checksum_reg) begin
                        state_next     = S_DONE;
                        done_next      = 1'b1;
                        cpu_rst_n_next = 1'b1;
                    end else begin
                        state_next = S_ERROR;
                        error_next = 1'b1;
                    end
                end
            endcase
        end else if (timer_run) begin
            if (timeout_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next = S_ERROR;
                error_next = 1'b1;
            end else begin
                timeout_next = timeout_reg + TW'(1);
            end
        end
    end

    // State and output registers.
    // The reset is synchronous and active low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= S_LENGTH;
            byte_cnt_reg  <= '0;
            word_reg      <= '0;
            count_reg     <= '0;
            index_reg     <= '0;
            checksum_reg  <= '0;
            timeout_reg   <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            cpu_rst_n_reg <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            word_reg      <= word_next;
            count_reg     <= count_next;
            index_reg     <= index_next;
            checksum_reg  <= checksum_next;
            timeout_reg   <= timeout_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            cpu_rst_n_reg <= cpu_rst_n_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    assign bus.io_mem_write_enable = we_reg;
    assign bus.io_mem_address      = addr_reg;
    assign bus.io_mem_write_data   = data_reg;
    assign io_cpu_reset_n          = cpu_rst_n_reg;
    assign io_load_done            = done_reg;
    assign io_load_error           = error_reg;
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader.
// The DUT is built with ADDR_WIDTH=4 and TIMEOUT_CYCLES=50.
module tb_uart_program_loader;
    logic clk = 1'b0;
    logic reset_n;
    logic io_reload;
    logic io_cpu_reset_n;
    logic io_load_done;
    logic io_load_error;

    int total = 0;
    int bad   = 0;

    uart_program_loader_if #(.ADDR_WIDTH(4)) bus ();

    uart_program_loader #(
        .ADDR_WIDTH    (4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .io_reload     (io_reload),
        .io_cpu_reset_n(io_cpu_reset_n),
        .io_load_done  (io_load_done),
        .io_load_error (io_load_error)
    );

    always #5 clk = ~clk;

    // Write monitor.
    // Records one entry per cycle the strobe is high.
    // A stuck strobe therefore inflates the count.
    int          wr_total = 0;
    logic [3:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    always @(negedge clk) begin
        if (bus.io_mem_write_enable === 1'b1) begin
            wr_addr[wr_total % 64] = bus.io_mem_address;
            wr_data[wr_total % 64] = bus.io_mem_write_data;
            wr_total = wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Presents one byte.
    // Returns 1 ns after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        bus.io_data_valid  = 1'b1;
        bus.io_data_packet = b;
        @(posedge clk); #1;
        bus.io_data_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        io_reload = 1'b1;
        @(posedge clk); #1;
        io_reload = 1'b0;
    endtask

    // Standard two-word frame.
    // gap = number of idle cycles between bytes.
    task automatic send_std(input logic [7:0] csum, input int gap);
        logic [7:0] fr [13];
        fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
               8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h00};
        fr[12] = csum;
        for (int i = 0; i < 13; i++) begin
            send_byte(fr[i]);
            if (gap > 0 && i < 12) idle(gap);
        end
    endtask

    task automatic check_std_writes(input string tag, input int base);
        chk({tag, "_wr_count"}, 32'(wr_total - base), 32'd2);
        chk({tag, "_addr0"}, 32'(wr_addr[base % 64]), 32'd0);
        chk({tag, "_data0"}, wr_data[base % 64], 32'h1122_3344);
        chk({tag, "_addr1"}, 32'(wr_addr[(base + 1) % 64]), 32'd1);
        chk({tag, "_data1"}, wr_data[(base + 1) % 64], 32'hAABB_CCDD);
    endtask

    initial begin
        int base;
        reset_n            = 1'b0;
        io_reload          = 1'b0;
        bus.io_data_valid  = 1'b0;
        bus.io_data_packet = 8'h00;
        idle(3);
        chk("rst_we", 32'(bus.io_mem_write_enable), 32'd0);
        chk("rst_addr", 32'(bus.io_mem_address), 32'd0);
        chk("rst_data", bus.io_mem_write_data, 32'd0);
        chk("rst_cpu", 32'(io_cpu_reset_n), 32'd0);
        chk("rst_done", 32'(io_load_done), 32'd0);
        chk("rst_err", 32'(io_load_error), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Good frame with gaps between bytes.
        base = wr_total;
        send_std(8'hBA, 2);
        chk("s1_done", 32'(io_load_done), 32'd1);
        chk("s1_cpu", 32'(io_cpu_reset_n), 32'd1);
        chk("s1_err", 32'(io_load_error), 32'd0);
        idle(2);
        check_std_writes("s1", base);

        // Bad checksum.
        pulse_reload();
        chk("rl_done", 32'(io_load_done), 32'd0);
        chk("rl_cpu", 32'(io_cpu_reset_n), 32'd0);
        base = wr_total;
        send_std(8'hBB, 1);
        chk("s2_err", 32'(io_load_error), 32'd1);
        chk("s2_done", 32'(io_load_done), 32'd0);
        chk("s2_cpu", 32'(io_cpu_reset_n), 32'd0);
        idle(2);
        chk("s2_wr_count", 32'(wr_total - base), 32'd2);

        // Empty image.
        pulse_reload();
        chk("rl2_err", 32'(io_load_error), 32'd0);
        base = wr_total;
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        chk("s3_done", 32'(io_load_done), 32'd1);
        chk("s3_cpu", 32'(io_cpu_reset_n), 32'd1);
        idle(2);
        chk("s3_wr_count", 32'(wr_total - base), 32'd0);

        // Length 17 exceeds 16 words.
        pulse_reload();
        base = wr_total;
        send_byte(8'h11);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("s4_err_early", 32'(io_load_error), 32'd0);
        send_byte(8'h00);
        chk("s4_err", 32'(io_load_error), 32'd1);
        chk("s4_done", 32'(io_load_done), 32'd0);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        idle(2);
        chk("s4_err_hold", 32'(io_load_error), 32'd1);
        chk("s4_wr_count", 32'(wr_total - base), 32'd0);

        // Timeout: the error flag rises exactly 50 edges after the last byte.
        pulse_reload();
        base = wr_total;
        send_byte(8'h02);
        idle(3);
        send_byte(8'h00);
        idle(49);
        chk("s5_err_49", 32'(io_load_error), 32'd0);
        idle(1);
        chk("s5_err_50", 32'(io_load_error), 32'd1);
        send_byte(8'h44);
        idle(2);
        chk("s5_err_hold", 32'(io_load_error), 32'd1);
        chk("s5_done", 32'(io_load_done), 32'd0);
        chk("s5_wr_count", 32'(wr_total - base), 32'd0);

        // Back-to-back bytes.
        pulse_reload();
        base = wr_total;
        send_std(8'hBA, 0);
        chk("s6_done", 32'(io_load_done), 32'd1);
        idle(2);
        check_std_writes("s6", base);

        // Reload coincident with a byte: the byte must be discarded.
        io_reload          = 1'b1;
        bus.io_data_valid  = 1'b1;
        bus.io_data_packet = 8'h02;
        @(posedge clk); #1;
        io_reload         = 1'b0;
        bus.io_data_valid = 1'b0;
        chk("s7_cpu", 32'(io_cpu_reset_n), 32'd0);
        chk("s7_done", 32'(io_load_done), 32'd0);
        chk("s7_err", 32'(io_load_error), 32'd0);
        base = wr_total;
        send_std(8'hBA, 0);
        chk("s7_done2", 32'(io_load_done), 32'd1);
        chk("s7_err2", 32'(io_load_error), 32'd0);
        idle(2);
        check_std_writes("s7", base);

        // Reset mid-frame, then a clean load.
        pulse_reload();
        send_byte(8'h02);
        send_byte(8'h00);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        chk("s8_done", 32'(io_load_done), 32'd0);
        chk("s8_err", 32'(io_load_error), 32'd0);
        base = wr_total;
        send_std(8'hBA, 1);
        chk("s8_done2", 32'(io_load_done), 32'd1);
        idle(2);
        check_std_writes("s8", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
